// File: rtl/dsp_rd_pkg.sv
// Shared types and constants for the DSP48E2 test-array P read-back path.
package dsp_rd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      STREAM
   } dsp_rd_state_t;

   localparam int DSP_P_W          = 48;
   localparam int DSP_MULT_LATENCY = 3;

   // Width of a lane index; a single-lane array still gets a 1-bit index.
   function automatic int lane_w(input int g_size);
      return (g_size > 1) ? $clog2(g_size) : 1;
   endfunction

endpackage

// File: rtl/dsp_p_reader.sv
// Captures every DSP slice's P output after the multiplier pipeline latency and
// streams the captured words lane by lane over a valid/ready interface.
module dsp_p_reader
   import dsp_rd_pkg::*;
#(
   parameter int G_SIZE  = 4,
   parameter int LATENCY = DSP_MULT_LATENCY,
   parameter int P_W     = DSP_P_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [G_SIZE*P_W-1:0]     p_in,
   output logic                      busy,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [P_W-1:0]            m_data,
   output logic [lane_w(G_SIZE)-1:0] m_lane,
   output logic                      m_last,
   output logic                      overrun
);

   localparam int LANE_W = lane_w(G_SIZE);
   localparam int CNT_W  = lane_w(LATENCY);
   localparam logic [LANE_W-1:0] LAST_IDX = LANE_W'(G_SIZE - 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);

   dsp_rd_state_t     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LANE_W-1:0] idx_q, idx_d;
   logic              overrun_q, overrun_d;
   logic [P_W-1:0]    buf_q [G_SIZE];

   logic capture;
   logic handshake;
   logic final_hs;

   assign capture   = (state_q == WAIT) && (cnt_q == '0);
   assign handshake = (state_q == STREAM) && m_ready;
   assign final_hs  = handshake && (idx_q == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         overrun_q <= overrun_d;
      end
   end

   // NOTE: the capture buffer is deliberately left without reset; it is only
   // read in STREAM, which is reachable solely through a capture.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < G_SIZE; i++) begin
            buf_q[i] <= p_in[i*P_W +: P_W];
         end
      end
   end

   // NOTE: every signal gets its hold value first so no path through the case
   // leaves one unassigned and infers a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      overrun_d = overrun_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         WAIT: begin
            if (start) overrun_d = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               idx_d   = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (final_hs) begin
               idx_d = '0;
               if (start) begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (start)     overrun_d = 1'b1;
               if (handshake) idx_d     = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs depend on registered state only, so m_ready never reaches m_valid.
   always_comb begin
      busy    = (state_q != IDLE);
      m_valid = (state_q == STREAM);
      m_data  = '0;
      m_lane  = '0;
      m_last  = 1'b0;
      if (m_valid) begin
         m_data = buf_q[idx_q];
         m_lane = idx_q;
         m_last = (idx_q == LAST_IDX);
      end
   end

   assign overrun = overrun_q;

endmodule

// File: tb/tb_dsp_p_reader.sv
// Directed bench for dsp_p_reader: a 4-lane/latency-3 instance and a
// 1-lane/latency-1 instance share clock and reset.
module tb_dsp_p_reader;
   import dsp_rd_pkg::*;

   localparam int G   = 4;
   localparam int LAT = 3;
   localparam int PW  = 48;
   localparam logic [PW-1:0] FILL = '1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          m_ready = 1'b1;
   logic [G*PW-1:0] p_in;
   logic          busy, m_valid, m_last, overrun;
   logic [PW-1:0] m_data;
   logic [1:0]    m_lane;

   logic          start1 = 1'b0;
   logic          m_ready1 = 1'b1;
   logic [PW-1:0] p_in1;
   logic          busy1, m_valid1, m_last1, overrun1;
   logic [PW-1:0] m_data1;
   logic [0:0]    m_lane1;

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [PW-1:0] exp_w [G];

   always #5 clk = ~clk;

   dsp_p_reader #(.G_SIZE(G), .LATENCY(LAT), .P_W(PW)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .p_in   (p_in),
      .busy   (busy),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data (m_data),
      .m_lane (m_lane),
      .m_last (m_last),
      .overrun(overrun)
   );

   dsp_p_reader #(.G_SIZE(1), .LATENCY(1), .P_W(PW)) dut1 (
      .clk    (clk),
      .rst    (rst),
      .start  (start1),
      .p_in   (p_in1),
      .busy   (busy1),
      .m_valid(m_valid1),
      .m_ready(m_ready1),
      .m_data (m_data1),
      .m_lane (m_lane1),
      .m_last (m_last1),
      .overrun(overrun1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic load_lanes(input logic [PW-1:0] a, b, c, d);
      exp_w = '{a, b, c, d};
      p_in  = {d, c, b, a};
   endtask

   task automatic check_word(input string tag, input int k);
      check({tag, "_valid"}, 64'(m_valid), 64'(1));
      check({tag, "_data"},  64'(m_data),  64'(exp_w[k]));
      check({tag, "_lane"},  64'(m_lane),  64'(k));
      check({tag, "_last"},  64'(m_last),  64'(k == G - 1));
   endtask

   // Accept words in order; with stall set, m_ready is low for the first five
   // valid cycles and then alternates 1,0,1,...
   task automatic drain(input bit stall, output int n_got);
      int n_stall;
      bit tog;
      bit rdy;
      n_stall = 0;
      tog     = 1'b1;
      n_got   = 0;
      for (int c = 0; c < 64 && n_got < G; c++) begin
         rdy = 1'b1;
         if (m_valid) begin
            check_word("drain", n_got);
            if (stall) begin
               if (n_stall < 5) begin
                  rdy = 1'b0;
                  n_stall++;
               end else begin
                  rdy = tog;
                  tog = ~tog;
               end
            end
         end
         m_ready = rdy;
         if (m_valid && rdy) n_got++;
         tick();
      end
      m_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int got;
      p_in  = {G{FILL}};
      p_in1 = FILL;
      tick();
      tick();

      // Reset values
      check("rst_busy",    64'(busy),    64'(0));
      check("rst_valid",   64'(m_valid), 64'(0));
      check("rst_data",    64'(m_data),  64'(0));
      check("rst_lane",    64'(m_lane),  64'(0));
      check("rst_last",    64'(m_last),  64'(0));
      check("rst_overrun", 64'(overrun), 64'(0));
      check("rst_busy1",   64'(busy1),   64'(0));
      rst = 1'b0;
      tick();

      // Basic capture: lanes valid only in cycle t+3
      start = 1'b1;
      tick();
      start = 1'b0;
      check("basic_busy_t1", 64'(busy), 64'(1));
      check("basic_valid_t1", 64'(m_valid), 64'(0));
      tick();
      tick();
      check("basic_valid_t3", 64'(m_valid), 64'(0));
      load_lanes(48'h1, 48'h2, 48'h3, 48'h4);
      for (int k = 0; k < G; k++) begin
         tick();
         p_in = {G{FILL}};
         check_word("basic", k);
      end
      tick();
      check("basic_busy_t8", 64'(busy), 64'(0));
      check("basic_valid_t8", 64'(m_valid), 64'(0));

      // Backpressure
      load_lanes(48'h11, 48'h22, 48'h33, 48'h44);
      start = 1'b1;
      tick();
      start = 1'b0;
      drain(1'b1, got);
      check("bp_words", 64'(got), 64'(G));
      check("bp_busy", 64'(busy), 64'(0));

      // Back-to-back: second start on the final handshake
      load_lanes(48'hA0, 48'hA1, 48'hA2, 48'hA3);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      for (int k = 0; k < G; k++) begin
         check_word("b2b_a", k);
         if (k == G - 1) start = 1'b1;
         tick();
      end
      start = 1'b0;
      load_lanes(48'hB0, 48'hB1, 48'hB2, 48'hB3);
      check("b2b_busy", 64'(busy), 64'(1));
      check("b2b_gap_valid", 64'(m_valid), 64'(0));
      check("b2b_overrun", 64'(overrun), 64'(0));
      tick();
      tick();
      check("b2b_gap2_valid", 64'(m_valid), 64'(0));
      tick();
      for (int k = 0; k < G; k++) begin
         check_word("b2b_b", k);
         tick();
      end
      check("b2b_end_busy", 64'(busy), 64'(0));
      check("b2b_end_overrun", 64'(overrun), 64'(0));

      // Overrun: second start two cycles after the first
      load_lanes(48'hC0, 48'hC1, 48'hC2, 48'hC3);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ovr_t1", 64'(overrun), 64'(0));
      tick();
      start = 1'b1;
      check("ovr_t2", 64'(overrun), 64'(0));
      tick();
      start = 1'b0;
      check("ovr_t3", 64'(overrun), 64'(1));
      drain(1'b0, got);
      check("ovr_words", 64'(got), 64'(G));
      for (int c = 0; c < 8; c++) begin
         check("ovr_no_rerun", 64'(m_valid), 64'(0));
         tick();
      end
      check("ovr_sticky", 64'(overrun), 64'(1));

      // Reset while lane 1 is on the bus
      load_lanes(48'hD0, 48'hD1, 48'hD2, 48'hD3);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      tick();
      check("rmid_valid", 64'(m_valid), 64'(1));
      check("rmid_lane", 64'(m_lane), 64'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rmid_valid_after", 64'(m_valid), 64'(0));
      check("rmid_data_after", 64'(m_data), 64'(0));
      check("rmid_busy_after", 64'(busy), 64'(0));
      check("rmid_overrun_after", 64'(overrun), 64'(0));
      for (int c = 0; c < 6; c++) begin
         check("rmid_quiet", 64'(m_valid), 64'(0));
         tick();
      end
      load_lanes(48'hE0, 48'hE1, 48'hE2, 48'hE3);
      start = 1'b1;
      tick();
      start = 1'b0;
      drain(1'b0, got);
      check("rmid_fresh_words", 64'(got), 64'(G));
      check("rmid_fresh_busy", 64'(busy), 64'(0));

      // Single lane, latency 1
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      p_in1  = 48'hABCD;
      check("g1_busy", 64'(busy1), 64'(1));
      check("g1_valid_t1", 64'(m_valid1), 64'(0));
      tick();
      p_in1 = FILL;
      check("g1_valid", 64'(m_valid1), 64'(1));
      check("g1_data", 64'(m_data1), 64'(48'hABCD));
      check("g1_lane", 64'(m_lane1), 64'(0));
      check("g1_last", 64'(m_last1), 64'(1));
      tick();
      check("g1_busy_end", 64'(busy1), 64'(0));
      check("g1_valid_end", 64'(m_valid1), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dsp_p_reader.md
# dsp_p_reader

Read-back end of the DSP48E2 test array: after operands are launched into G_SIZE multiplier-mode DSP48E2 slices (AREG=BREG=2, MREG=1, PREG=0), the block waits the fixed pipeline latency and captures every slice's P output into a local buffer. It then streams the captured words one lane at a time over a valid/ready interface to the host-side logger. It sits between the DSP array and the readback FIFO, and is the only consumer of the array's P buses.

## Interface
- G_SIZE, 4, number of DSP slices read; must be ≥1
- LATENCY, 3, cycles from operand launch to valid P (AREG 2 + MREG 1); must be ≥1
- P_W, 48, width of each P bus
- clk  in  1  single clock for the block and the DSP array
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: operands presented to the array this cycle
- p_in  in  G_SIZE*P_W  concatenated P buses; lane i at bits [i*P_W +: P_W]
- busy  out  1  high in any state other than IDLE
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts the word
- m_data  out  P_W  captured P of lane m_lane
- m_lane  out  max(1,$clog2(G_SIZE))  lane index of m_data
- m_last  out  1  high with the word of lane G_SIZE-1
- overrun  out  1  sticky: a start arrived while busy and was dropped

## Operation
- States: IDLE, WAIT, STREAM.
- IDLE: start=1 → WAIT with cnt ← LATENCY-1.
- WAIT: cnt≠0 → cnt decrements. cnt=0 → capture all G_SIZE lanes of p_in into buf, idx ← 0, → STREAM.
- STREAM: m_valid=1, m_data=buf[idx], m_lane=idx, m_last=(idx==G_SIZE-1).
  - Handshake (m_valid & m_ready) with m_last=0 → idx increments.
  - Handshake with m_last=1 → IDLE.
- While m_valid=1 & m_ready=0: m_data, m_lane and m_last are held stable.
- start in WAIT, or in STREAM without the final handshake: ignored, overrun ← 1.
- start in the same cycle as the final handshake: accepted without overrun; next state WAIT, cnt ← LATENCY-1 (back-to-back runs).
- G_SIZE=1: the single word carries m_last=1 and m_lane=0.
- overrun is cleared only by rst.
- When m_valid=0: m_data, m_lane and m_last are driven to 0.
- buf is not reset; its contents are only observable after a capture.

## Timing
- Reset values: state IDLE, busy=0, m_valid=0, m_data=0, m_lane=0, m_last=0, overrun=0, cnt=0, idx=0.
- rst mid-operation (WAIT or STREAM): next cycle IDLE with all outputs at reset values; the partial run is discarded and no word is emitted.
- start sampled at edge t → busy=1 from cycle t+1.
- Capture at the edge ending cycle t+LATENCY (LATENCY=3: p_in sampled in cycle t+3).
- First m_valid in cycle t+LATENCY+1.
- With m_ready held at 1: one word per cycle, last word in cycle t+LATENCY+G_SIZE, busy=0 from the following cycle.
- Minimum start-to-start period is LATENCY+G_SIZE cycles, using the back-to-back rule.
- No combinational path from m_ready to m_valid.

## Structure
- Package dsp_rd_pkg holds:
  - enum dsp_rd_state_t {IDLE, WAIT, STREAM}
  - DSP_P_W = 48
  - DSP_MULT_LATENCY = 3, which is the default source for LATENCY
  - function lane_w(G_SIZE) returning max(1,$clog2(G_SIZE))
- Single module, no sub-module: the counter, buffer and FSM are small enough to keep flat.
- buf is an unpacked array of G_SIZE × P_W registers.

## Test plan
- Basic capture:
  - Stimulus: G_SIZE=4, LATENCY=3, m_ready=1. Drive p_in lanes 0..3 = 0x1, 0x2, 0x3, 0x4 only in cycle t+3 (other cycles 0xFFFF…), start at t.
  - Required: words 0x1..0x4 on lanes 0..3 in cycles t+4..t+7, m_last only at t+7, busy=0 at t+8.
- Backpressure:
  - Stimulus: m_ready=0 for 5 cycles after the first m_valid, then toggle 1,0,1,0,….
  - Required: m_data/m_lane held stable while stalled, all 4 words delivered in order, no duplicates or drops.
- Overrun:
  - Stimulus: start at t, start again at t+2.
  - Required: overrun=1 from t+3 and stays 1, exactly 4 words emitted, second start ignored.
- Back-to-back:
  - Stimulus: second start coincident with the final handshake.
  - Required: overrun stays 0, second capture LATENCY cycles later, 8 words total.
- Reset mid-stream:
  - Stimulus: rst=1 while m_valid=1 on lane 1.
  - Required: next cycle m_valid=0, m_data=0, busy=0, overrun=0, no further words.
  - Follow-up: a fresh start then works normally.
- G_SIZE=1, LATENCY=1:
  - Stimulus: start at t, p_in=0xABCD in cycle t+1.
  - Required: one word 0xABCD in cycle t+2 with m_last=1, m_lane=0.
